// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: word width, canonical NOP, base opcodes
// used by decode, and the fetch-stage state encoding.
package rv_pkg;

  localparam int WORD_SIZE = 32;

  // ADDI x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instr} between the imem response and decode.
// Control (pointers, count) is reset; the storage itself is not.
module fetch_queue #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WORD_SIZE-1:0] push_pc,
  input  logic [WORD_SIZE-1:0] push_instr,
  input  logic                 pop,
  input  logic                 clear,
  output logic                 empty,
  output logic [1:0]           count,
  output logic [WORD_SIZE-1:0] head_pc,
  output logic [WORD_SIZE-1:0] head_instr
);

  logic [WORD_SIZE-1:0] pc_mem    [2];
  logic [WORD_SIZE-1:0] instr_mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           cnt;

  // Pointer and occupancy tracking; clear wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; a same-cycle pop of the full slot frees it for this write.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  assign empty      = (cnt == 2'd0);
  assign count      = cnt;
  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  // The fetch credit rule must keep the queue from overflowing or underflowing.
  assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && !clear && cnt == 2'd2));
  assert property (@(posedge clk) disable iff (rst)
    !(pop && !clear && cnt == 2'd0));

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage RV32I pipeline.
// Owns the PC, issues word reads to a synchronous imem (1-cycle latency),
// buffers responses in a 2-entry queue and hands {pc, instr} to decode.
// Optional build macro IF_STALL_CNT_EN adds the if_stall_cnt output counting
// cycles in which decode was ready but fetch had nothing to offer.
module if_stage #(
  parameter int                   WORD_SIZE = 32,
  parameter int                   ADDR_SIZE = 10,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [ADDR_SIZE-1:0] imem_addr,
  input  logic [WORD_SIZE-1:0] imem_rdata,
  output logic                 id_valid,
  input  logic                 id_ready,
  output logic [WORD_SIZE-1:0] id_instr,
  output logic [WORD_SIZE-1:0] id_pc,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 misalign_fault
`ifdef IF_STALL_CNT_EN
  ,
  output logic [31:0]          if_stall_cnt
`endif
);

  import rv_pkg::*;

  fetch_state_e         state;
  fetch_state_e         state_nxt;
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] req_pc_p1;
  logic                 inflight;
  logic                 pop;
  logic                 push;
  logic                 credit_ok;
  logic [2:0]           credit_used;
  logic                 q_empty;
  logic [1:0]           q_count;
  logic [WORD_SIZE-1:0] head_pc;
  logic [WORD_SIZE-1:0] head_instr;
  logic [WORD_SIZE-1:0] redirect_target;

  assign pop             = id_valid && id_ready;
  assign redirect_target = {redirect_pc[WORD_SIZE-1:2], 2'b00};

  // A slot is reserved for every queued entry and the outstanding response;
  // a pop this cycle hands one back, which is what sustains 1 instr/cycle.
  assign credit_used = {1'b0, q_count} + {2'b00, inflight};
  assign credit_ok   = credit_used < (3'd2 + {2'b00, pop});

  // Fetch state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_BOOT;
    else     state <= state_nxt;
  end

  // Next-state and request decision; a redirect overrides everything.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    unique case (state)
      S_BOOT:  state_nxt = S_RUN;
      S_RUN:   imem_req  = credit_ok;
      S_FLUSH: state_nxt = S_RUN;
      default: state_nxt = S_BOOT;
    endcase
    if (redirect_valid) begin
      state_nxt = S_FLUSH;
      imem_req  = 1'b0;
    end
  end

  // ---- p0: request issue (pc -> imem) ----
  assign imem_addr = pc[ADDR_SIZE+1:2];

  // PC, outstanding-response flag and sticky misalignment flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc             <= RESET_PC;
      inflight       <= 1'b0;
      misalign_fault <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (redirect_valid) begin
        pc <= redirect_target;
        if (redirect_pc[1:0] != 2'b00) misalign_fault <= 1'b1;
      end else if (imem_req) begin
        pc <= pc + WORD_SIZE'(4);
      end
    end
  end

  // Remember which PC the outstanding response belongs to.
  always_ff @(posedge clk) begin
    if (imem_req) req_pc_p1 <= pc;
  end

  // ---- p1: response capture into queue ----
  assign push = inflight && !redirect_valid;

  fetch_queue #(
    .WORD_SIZE (WORD_SIZE)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_pc    (req_pc_p1),
    .push_instr (imem_rdata),
    .pop        (pop),
    .clear      (redirect_valid),
    .empty      (q_empty),
    .count      (q_count),
    .head_pc    (head_pc),
    .head_instr (head_instr)
  );

  // ---- p2: decode handoff ----
  assign id_valid = !q_empty;
  assign id_instr = q_empty ? WORD_SIZE'(NOP_INSTR) : head_instr;
  assign id_pc    = q_empty ? '0 : head_pc;

`ifdef IF_STALL_CNT_EN
  // Saturating count of cycles where decode was starved by fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      if_stall_cnt <= '0;
    else if (id_ready && !id_valid && (if_stall_cnt != 32'hFFFF_FFFF))
      if_stall_cnt <= if_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: scenario tasks plus a stream monitor that
// models fetch as an in-order PC sequence with at most two words owed to decode.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        misalign_fault;
`ifdef IF_STALL_CNT_EN
  logic [31:0] if_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // reference-model state
  logic [31:0] exp_pc, fetch_pc, exp_stall, hold_pc, hold_instr;
  logic        exp_mis, hold_prev, redir_prev;
  int          outst;
  int          n_acc = 0;

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_fault (misalign_fault)
`ifdef IF_STALL_CNT_EN
    ,
    .if_stall_cnt   (if_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [9:0] wa);
    if (wa == 10'd0) return 32'h0050_0093;
    if (wa == 10'd1) return 32'h00A0_0113;
    return (32'(wa) * 32'h9E37_79B1) ^ {wa, 22'h0} ^ 32'h0000_0013;
  endfunction

  // Synchronous instruction memory; junk on idle cycles exposes bad captures.
  always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom();

  // Stream monitor: sampled after inputs for the coming edge are settled.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      exp_pc = '0; fetch_pc = '0; outst = 0; exp_mis = 1'b0; exp_stall = '0;
      hold_prev = 1'b0; redir_prev = 1'b0;
    end else begin
      total++;
      if (misalign_fault !== exp_mis) begin
        bad++; $display("FAIL mon_misalign: got %b want %b", misalign_fault, exp_mis);
      end
`ifdef IF_STALL_CNT_EN
      total++;
      if (if_stall_cnt !== exp_stall) begin
        bad++; $display("FAIL mon_stall_cnt: got %0d want %0d", if_stall_cnt, exp_stall);
      end
`endif
      if (!id_valid) begin
        total++;
        if (id_instr !== NOP || id_pc !== 32'h0) begin
          bad++; $display("FAIL mon_idle_out: got instr=%h pc=%h want %h/0", id_instr, id_pc, NOP);
        end
      end
      if (redir_prev) begin
        total++;
        if (id_valid !== 1'b0) begin
          bad++; $display("FAIL mon_flush_valid: got %b want 0", id_valid);
        end
      end
      if (hold_prev) begin
        total++;
        if (id_valid !== 1'b1 || id_pc !== hold_pc || id_instr !== hold_instr) begin
          bad++; $display("FAIL mon_hold: got v=%b pc=%h i=%h want pc=%h i=%h",
                          id_valid, id_pc, id_instr, hold_pc, hold_instr);
        end
      end
      if (id_valid && id_ready) begin
        total++;
        if (id_pc !== exp_pc || id_instr !== mem_word(exp_pc[11:2])) begin
          bad++; $display("FAIL mon_stream: got pc=%h i=%h want pc=%h i=%h",
                          id_pc, id_instr, exp_pc, mem_word(exp_pc[11:2]));
        end
        exp_pc = exp_pc + 32'd4; outst--; n_acc++;
      end
      if (imem_req) begin
        total++;
        if (redirect_valid || imem_addr !== fetch_pc[11:2] || outst >= 2) begin
          bad++; $display("FAIL mon_request: got addr=%h outst=%0d redir=%b want addr=%h",
                          imem_addr, outst, redirect_valid, fetch_pc[11:2]);
        end
        fetch_pc = fetch_pc + 32'd4; outst++;
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc & ~32'h3; fetch_pc = redirect_pc & ~32'h3; outst = 0;
        if (redirect_pc[1:0] != 2'b00) exp_mis = 1'b1;
      end
      if (id_ready && !id_valid && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
      hold_prev  = id_valid && !id_ready && !redirect_valid;
      hold_pc    = id_pc;
      hold_instr = id_instr;
      redir_prev = redirect_valid;
    end
  end

  task automatic test_reset;
    #1;
    total++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 32'h0 ||
        misalign_fault !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: got req=%b v=%b i=%h pc=%h mf=%b want 0/0/%h/0/0",
                      imem_req, id_valid, id_instr, id_pc, misalign_fault, NOP);
    end
`ifdef IF_STALL_CNT_EN
    total++;
    if (if_stall_cnt !== 32'h0) begin
      bad++; $display("FAIL reset_stall_cnt: got %0d want 0", if_stall_cnt);
    end
`endif
    repeat (2) begin
      @(negedge clk); #1;
      total++;
      if (imem_req !== 1'b0) begin
        bad++; $display("FAIL reset_hold_req: got %b want 0", imem_req);
      end
    end
  endtask

  task automatic test_first_fetch;
    @(negedge clk); rst = 1'b0; id_ready = 1'b1; #1;
    total++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0) begin
      bad++; $display("FAIL boot_cycle: got req=%b v=%b want 0/0", imem_req, id_valid);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      total++;
      if (k < 3) begin
        if (imem_req !== 1'b1 || imem_addr !== 10'(k - 1) || id_valid !== 1'b0) begin
          bad++; $display("FAIL first_req_%0d: got req=%b addr=%h v=%b want 1/%h/0",
                          k, imem_req, imem_addr, id_valid, k - 1);
        end
      end else if (id_valid !== 1'b1 || id_pc !== 32'((k - 3) * 4)) begin
        bad++; $display("FAIL first_stream_%0d: got v=%b pc=%h want 1/%h",
                        k, id_valid, id_pc, (k - 3) * 4);
      end
      if (k == 3 || k == 4) begin
        total++;
        if (id_instr !== (k == 3 ? 32'h0050_0093 : 32'h00A0_0113)) begin
          bad++; $display("FAIL first_instr_%0d: got %h", k, id_instr);
        end
      end
`ifdef IF_STALL_CNT_EN
      if (k == 3) begin
        total++;
        if (if_stall_cnt !== 32'd3) begin
          bad++; $display("FAIL boot_stall_cnt: got %0d want 3", if_stall_cnt);
        end
      end
`endif
    end
  endtask

  task automatic test_redirect;
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    total++;
    if (imem_req !== 1'b0 || id_valid !== 1'b1) begin
      bad++; $display("FAIL redir_cycle: got req=%b v=%b want 0/1", imem_req, id_valid);
    end
    @(negedge clk); redirect_valid = 1'b0; #1;
    total++;
    if (id_valid !== 1'b0 || imem_req !== 1'b0) begin
      bad++; $display("FAIL redir_flush: got v=%b req=%b want 0/0", id_valid, imem_req);
    end
    @(negedge clk); #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h010 || id_valid !== 1'b0) begin
      bad++; $display("FAIL redir_req: got req=%b addr=%h v=%b want 1/010/0", imem_req, imem_addr, id_valid);
    end
    @(negedge clk); #1;
    total++;
    if (id_valid !== 1'b0) begin
      bad++; $display("FAIL redir_capture: got v=%b want 0", id_valid);
    end
    @(negedge clk); #1;
    total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== mem_word(10'h010)) begin
      bad++; $display("FAIL redir_first: got v=%b pc=%h i=%h want 1/40/%h",
                      id_valid, id_pc, id_instr, mem_word(10'h010));
    end
`ifdef IF_STALL_CNT_EN
    total++;
    if (if_stall_cnt !== 32'd6) begin
      bad++; $display("FAIL flush_stall_cnt: got %0d want 6", if_stall_cnt);
    end
`endif
  endtask

  task automatic test_stall;
    logic [31:0] p, ins;
    @(negedge clk); id_ready = 1'b0; #1;
    p = id_pc; ins = id_instr;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      total++;
      if (id_valid !== 1'b1 || id_pc !== p || id_instr !== ins) begin
        bad++; $display("FAIL stall_stable_%0d: got pc=%h i=%h want %h/%h", k, id_pc, id_instr, p, ins);
      end
    end
    total++;
    if (imem_req !== 1'b0) begin
      bad++; $display("FAIL stall_req_stop: got %b want 0", imem_req);
    end
    @(negedge clk); id_ready = 1'b1;
    @(negedge clk); #1;
    total++;
    if (id_valid !== 1'b1 || id_pc !== p + 32'd4) begin
      bad++; $display("FAIL stall_release: got v=%b pc=%h want 1/%h", id_valid, id_pc, p + 32'd4);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_redirect_stalled;
    int n;
    @(negedge clk); id_ready = 1'b0;
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    @(negedge clk); redirect_valid = 1'b0; #1;
    total++;
    if (id_valid !== 1'b0) begin
      bad++; $display("FAIL redir_full_kill: got v=%b want 0", id_valid);
    end
    id_ready = 1'b1; n = 0;
    do begin @(negedge clk); #1; n++; end while (!id_valid && n < 8);
    total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h80) begin
      bad++; $display("FAIL redir_full_first: got v=%b pc=%h want 1/80", id_valid, id_pc);
    end
  endtask

  task automatic test_misalign;
    int n;
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h42; #1;
    total++;
    if (misalign_fault !== 1'b0) begin
      bad++; $display("FAIL misalign_early: got %b want 0", misalign_fault);
    end
    @(negedge clk); redirect_valid = 1'b0; #1;
    total++;
    if (misalign_fault !== 1'b1) begin
      bad++; $display("FAIL misalign_set: got %b want 1", misalign_fault);
    end
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!id_valid && n < 8);
    total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h40) begin
      bad++; $display("FAIL misalign_resume: got v=%b pc=%h want 1/40", id_valid, id_pc);
    end
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk); redirect_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (misalign_fault !== 1'b1 || id_pc !== 32'h104) begin
      bad++; $display("FAIL misalign_sticky: got mf=%b pc=%h want 1/104", misalign_fault, id_pc);
    end
  endtask

  task automatic test_wrap;
    int n;
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk); redirect_valid = 1'b0; n = 0;
    do begin @(negedge clk); #1; n++; end while (!id_valid && n < 8);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      total++;
      if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFF8 + 32'(k * 4)) begin
        bad++; $display("FAIL wrap_%0d: got v=%b pc=%h want 1/%h", k, id_valid, id_pc, 32'hFFFF_FFF8 + 32'(k * 4));
      end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk); redirect_pc = 32'h300; #1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++; $display("FAIL b2b_second: got req=%b want 0", imem_req);
    end
    @(negedge clk); redirect_valid = 1'b0; #1;
    total++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_flush: got req=%b v=%b want 0/0", imem_req, id_valid);
    end
    @(negedge clk); #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h0C0) begin
      bad++; $display("FAIL b2b_req: got req=%b addr=%h want 1/0c0", imem_req, imem_addr);
    end
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!id_valid && n < 8);
    total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h300) begin
      bad++; $display("FAIL b2b_first: got v=%b pc=%h want 1/300", id_valid, id_pc);
    end
  endtask

  task automatic test_boot_redirect;
    int n;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h500; #1;
    total++;
    if (imem_req !== 1'b0 || misalign_fault !== 1'b0) begin
      bad++; $display("FAIL boot_redir: got req=%b mf=%b want 0/0", imem_req, misalign_fault);
    end
    @(negedge clk); redirect_valid = 1'b0; #1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++; $display("FAIL boot_redir_flush: got req=%b want 0", imem_req);
    end
    @(negedge clk); #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h140) begin
      bad++; $display("FAIL boot_redir_req: got req=%b addr=%h want 1/140", imem_req, imem_addr);
    end
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!id_valid && n < 8);
    total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h500) begin
      bad++; $display("FAIL boot_redir_first: got v=%b pc=%h want 1/500", id_valid, id_pc);
    end
  endtask

  task automatic test_random;
    int acc0;
    logic [31:0] t;
    acc0 = n_acc;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      id_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      t = $urandom();
      if ($urandom_range(0, 4) != 0) t[1:0] = 2'b00;
      redirect_pc = t;
    end
    @(negedge clk); redirect_valid = 1'b0; id_ready = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (n_acc - acc0 < 60) begin
      bad++; $display("FAIL random_progress: got %0d accepted want >= 60", n_acc - acc0);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    id_ready = 1'b1;
    @(negedge clk); #3; rst = 1'b1; #1;
    total++;
    if (id_valid !== 1'b0 || imem_req !== 1'b0 || misalign_fault !== 1'b0 ||
        id_instr !== NOP || id_pc !== 32'h0) begin
      bad++; $display("FAIL reset_async: got v=%b req=%b mf=%b i=%h pc=%h",
                      id_valid, imem_req, misalign_fault, id_instr, id_pc);
    end
    @(negedge clk);
    @(negedge clk); rst = 1'b0; n = 0;
    do begin @(negedge clk); #1; n++; end while (!id_valid && n < 8);
    total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h0050_0093) begin
      bad++; $display("FAIL reset_restart: got v=%b pc=%h i=%h want 1/0/00500093", id_valid, id_pc, id_instr);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_redirect();
    test_stall();
    test_redirect_stalled();
    test_misalign();
    test_wrap();
    test_back_to_back();
    test_boot_redirect();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
